// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - command handshake bundle for the CPU run controller
//
// Carries one run command from the debug/PDU front end to cpu_run_ctrl.
//   cmd_valid  master->slave  command request
//   cmd_ready  slave->master  command accepted when cmd_valid & cmd_ready
//   cmd_op     master->slave  00 NOP, 01 STEP, 10 RUN (free), 11 RUN_N
//   cmd_count  master->slave  cycle count for RUN_N
//   bp_en      master->slave  breakpoint enable, sampled at accept
//   bp_addr    master->slave  breakpoint PC, sampled at accept
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;

  modport master (
    output cmd_valid, cmd_op, cmd_count, bp_en, bp_addr,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, bp_en, bp_addr,
    output cmd_ready
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run-sequencing controller owning the CPU clock enable
//
// Accepts STEP / RUN / RUN_N commands, gates the CPU with a registered run
// enable, stops on cpu_halt, user abort, PC breakpoint or count exhaustion and
// reports the stop cause and the number of cycles the CPU ran.
// Optional free-run watchdog: define RUN_WATCHDOG_EN (limit = WDOG_LIMIT).
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   cmd          command handshake (cpu_run_ctrl_if.slave)
//   if_pc        CPU fetch-stage PC, compared against the latched breakpoint
//   cpu_halt     CPU reports it has stopped
//   stop_req     user abort, level or pulse
//   cpu_run      registered CPU clock enable
//   busy         high from accept until the done pulse ends
//   done         one-cycle completion pulse
//   stop_cause   0 none, 1 count, 2 breakpoint, 3 cpu_halt, 4 user, 5 watchdog
//   cycles_run   cycles cpu_run was high in the last/current command
module cpu_run_ctrl #(
  parameter int          CNT_W      = 16,
  parameter int          PC_W       = 32,
  parameter logic [31:0] WDOG_LIMIT = 32'h00FF_FFFF
) (
  input  logic                 clk,
  input  logic                 rstn,
  cpu_run_ctrl_if.slave        cmd,
  input  logic [PC_W-1:0]      if_pc,
  input  logic                 cpu_halt,
  input  logic                 stop_req,
  output logic                 cpu_run,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           stop_cause,
  output logic [31:0]          cycles_run
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_RUN_N = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             bp_en_q, bp_en_d;
  logic [PC_W-1:0]  bp_addr_q, bp_addr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;
  logic             cpu_run_q, cpu_run_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [2:0]       stop_cause_q, stop_cause_d;
  logic [31:0]      cycles_run_q, cycles_run_d;

  logic [31:0]      cycles_inc;
  logic             counted;
  logic             bp_hit;
  logic             wdog_hit;
  logic [2:0]       cause_now;

`ifdef RUN_WATCHDOG_EN
  // cycles_inc is the count including the current RUN cycle, so the stop
  // lands after exactly WDOG_LIMIT enabled cycles.
  assign wdog_hit = (op_q == OP_RUN) && (cycles_inc == WDOG_LIMIT);
`else
  assign wdog_hit = 1'b0;
  wire unused_wdog_limit = ^WDOG_LIMIT;
`endif

  always_comb begin
    cycles_inc = (cycles_run_q == 32'hFFFF_FFFF) ? cycles_run_q : cycles_run_q + 32'd1;
    counted    = (op_q == OP_STEP) || (op_q == OP_RUN_N);
    // The first RUN cycle ignores the breakpoint so a halted-at-breakpoint
    // CPU can be resumed from the same PC.
    bp_hit     = bp_en_q && !first_q && (if_pc == bp_addr_q);

    if (cpu_halt)                                  cause_now = 3'd3;
    else if (stop_req)                             cause_now = 3'd4;
    else if (bp_hit)                               cause_now = 3'd2;
    else if (counted && remaining_q == CNT_W'(1))  cause_now = 3'd1;
    else if (wdog_hit)                             cause_now = 3'd5;
    else                                           cause_now = 3'd0;
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    bp_en_d      = bp_en_q;
    bp_addr_d    = bp_addr_q;
    remaining_d  = remaining_q;
    first_d      = first_q;
    cpu_run_d    = cpu_run_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cmd_ready_d  = cmd_ready_q;
    stop_cause_d = stop_cause_q;
    cycles_run_d = cycles_run_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && cmd_ready_q) begin
          op_d         = cmd.cmd_op;
          bp_en_d      = cmd.bp_en;
          bp_addr_d    = cmd.bp_addr;
          remaining_d  = (cmd.cmd_op == OP_STEP) ? CNT_W'(1) : cmd.cmd_count;
          cmd_ready_d  = 1'b0;
          busy_d       = 1'b1;
          cycles_run_d = 32'd0;
          if ((cmd.cmd_op == OP_NOP) ||
              ((cmd.cmd_op == OP_RUN_N) && (cmd.cmd_count == '0))) begin
            // Zero-length command: completes without ever enabling the CPU.
            state_d      = S_DONE;
            done_d       = 1'b1;
            stop_cause_d = (cmd.cmd_op == OP_NOP) ? 3'd0 : 3'd1;
          end else begin
            state_d      = S_START;
            stop_cause_d = 3'd0;
          end
        end
      end
      S_START: begin
        cpu_run_d = 1'b1;
        first_d   = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        cycles_run_d = cycles_inc;
        first_d      = 1'b0;
        if (counted) remaining_d = remaining_q - CNT_W'(1);
        if (cause_now != 3'd0) begin
          cpu_run_d    = 1'b0;
          state_d      = S_DONE;
          done_d       = 1'b1;
          stop_cause_d = cause_now;
        end
      end
      S_DONE: begin
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      bp_en_q      <= 1'b0;
      bp_addr_q    <= '0;
      remaining_q  <= '0;
      first_q      <= 1'b0;
      cpu_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      stop_cause_q <= 3'd0;
      cycles_run_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      bp_en_q      <= bp_en_d;
      bp_addr_q    <= bp_addr_d;
      remaining_q  <= remaining_d;
      first_q      <= first_d;
      cpu_run_q    <= cpu_run_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cmd_ready_q  <= cmd_ready_d;
      stop_cause_q <= stop_cause_d;
      cycles_run_q <= cycles_run_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign cpu_run       = cpu_run_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign stop_cause    = stop_cause_q;
  assign cycles_run    = cycles_run_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl
module tb_cpu_run_ctrl;
  localparam int          CNT_W = 16;
  localparam int          PC_W  = 32;
  localparam int          LMAX  = 48;
  localparam logic [31:0] WD    = 32'd8;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.CNT_W(CNT_W), .PC_W(PC_W)) cif ();

  logic [PC_W-1:0] if_pc;
  logic            cpu_halt, stop_req;
  logic            cpu_run, busy, done;
  logic [2:0]      stop_cause;
  logic [31:0]     cycles_run;

  cpu_run_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W), .WDOG_LIMIT(WD)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd        (cif.slave),
    .if_pc      (if_pc),
    .cpu_halt   (cpu_halt),
    .stop_req   (stop_req),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .done       (done),
    .stop_cause (stop_cause),
    .cycles_run (cycles_run)
  );

  typedef struct {
    logic [2:0]  cause;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   run_cnt = 0;

  // Per-RUN-cycle stimulus, index k = k-th cycle with cpu_run high.
  logic            h_a  [0:LMAX];
  logic            s_a  [0:LMAX];
  logic [PC_W-1:0] pc_a [0:LMAX];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the run cycles; the first cycle with any stop condition
  // ends the command with the highest-priority cause of that cycle.
  function automatic exp_t model(input logic [1:0] op, input int cnt,
                                 input logic be, input logic [PC_W-1:0] ba);
    exp_t e;
    e.cause = 3'd0;
    e.cyc   = 32'd0;
    if (op == 2'd0) return e;
    if (op == 2'd3 && cnt == 0) begin
      e.cause = 3'd1;
      return e;
    end
    for (int k = 1; k <= LMAX; k++) begin
      e.cyc = k;
      if (h_a[k])                               e.cause = 3'd3;
      else if (s_a[k])                          e.cause = 3'd4;
      else if (be && k > 1 && pc_a[k] == ba)    e.cause = 3'd2;
      else if ((op == 2'd1 && k == 1) || (op == 2'd3 && k == cnt)) e.cause = 3'd1;
`ifdef RUN_WATCHDOG_EN
      else if (op == 2'd2 && k == int'(WD))     e.cause = 3'd5;
`endif
      if (e.cause != 3'd0) return e;
    end
    return e;
  endfunction

  task automatic clear_arrays();
    for (int k = 0; k <= LMAX; k++) begin
      h_a[k]  = 1'b0;
      s_a[k]  = 1'b0;
      pc_a[k] = '0;
    end
    s_a[LMAX] = 1'b1;
  endtask

  task automatic rand_arrays(input logic [PC_W-1:0] ba);
    for (int k = 0; k <= LMAX; k++) begin
      h_a[k]  = ($urandom % 25) == 0;
      s_a[k]  = ($urandom % 25) == 0;
      pc_a[k] = (($urandom % 6) == 0) ? ba : PC_W'($urandom);
    end
    s_a[LMAX] = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input int cnt, input logic be, input logic [PC_W-1:0] ba);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!cif.cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cif.cmd_ready) begin
      chk("cmd_ready_timeout", 32'(cif.cmd_ready), 32'd1);
      return;
    end
    e = model(op, cnt, be, ba);
    exp_q.push_back(e);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_count = CNT_W'(cnt);
    cif.bp_en     = be;
    cif.bp_addr   = ba;
    cpu_halt      = $urandom % 2;   // no effect in IDLE
    stop_req      = $urandom % 2;
    if_pc         = PC_W'($urandom);
    @(negedge clk);
    // START (or DONE for zero-length): scramble command fields to prove
    // they were latched, and wiggle halt/abort to prove they are ignored.
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'($urandom);
    cif.cmd_count = CNT_W'($urandom);
    cif.bp_en     = 1'($urandom);
    cif.bp_addr   = PC_W'($urandom);
    cpu_halt      = $urandom % 2;
    stop_req      = $urandom % 2;
    for (int k = 1; k <= int'(e.cyc); k++) begin
      @(negedge clk);
      cpu_halt      = h_a[k];
      stop_req      = s_a[k];
      if_pc         = pc_a[k];
      cif.cmd_valid = ($urandom % 4) == 0;
    end
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    cpu_halt      = 1'b0;
    stop_req      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      run_cnt = 0;
    end else begin
      if (cpu_run) run_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("stop_cause", 32'(stop_cause), 32'(mon_e.cause));
          chk("cycles_run", cycles_run, mon_e.cyc);
          chk("cpu_run_high_cycles", 32'(run_cnt), mon_e.cyc);
          chk("busy_at_done", 32'(busy), 32'd1);
          chk("cmd_ready_at_done", 32'(cif.cmd_ready), 32'd0);
        end
        run_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [1:0]      op;
    int              cnt;
    logic            be;
    logic [PC_W-1:0] ba;
    int              t;

    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'd0;
    cif.cmd_count = '0;
    cif.bp_en     = 1'b0;
    cif.bp_addr   = '0;
    if_pc         = '0;
    cpu_halt      = 1'b0;
    stop_req      = 1'b0;

    #2 rstn = 1'b0;
    #1;
    chk("rst_cpu_run",    32'(cpu_run),       32'd0);
    chk("rst_busy",       32'(busy),          32'd0);
    chk("rst_done",       32'(done),          32'd0);
    chk("rst_cmd_ready",  32'(cif.cmd_ready), 32'd1);
    chk("rst_stop_cause", 32'(stop_cause),    32'd0);
    chk("rst_cycles_run", cycles_run,         32'd0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;

    // Directed cases from the run-control rules.
    clear_arrays(); issue(2'd1, 0, 1'b0, 32'h0);                 // STEP -> 1/1
    clear_arrays(); issue(2'd3, 5, 1'b0, 32'h0);                 // RUN_N 5 -> 1/5
    clear_arrays(); issue(2'd3, 0, 1'b0, 32'h0);                 // RUN_N 0 -> 1/0
    clear_arrays(); pc_a[3] = 32'h40; issue(2'd2, 0, 1'b1, 32'h40);   // bp -> 2/3
    clear_arrays(); pc_a[1] = 32'h40; s_a[6] = 1'b1;
    issue(2'd2, 0, 1'b1, 32'h40);                                // resume at bp -> 4/6
    clear_arrays(); h_a[4] = 1'b1; s_a[4] = 1'b1;
    issue(2'd3, 10, 1'b0, 32'h0);                                // halt beats abort -> 3/4
    clear_arrays(); s_a[20] = 1'b1; issue(2'd2, 0, 1'b0, 32'h0); // free run past 8
    clear_arrays(); issue(2'd0, 0, 1'b0, 32'h0);                 // NOP -> 0/0
    clear_arrays(); pc_a[1] = 32'h80; issue(2'd1, 0, 1'b1, 32'h80);   // STEP at bp -> 1/1

    // Reset in the middle of a free run.
    clear_arrays();
    t = 0;
    @(negedge clk);
    while (!cif.cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'd2;
    cif.bp_en     = 1'b0;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'd1;
    chk("mid_run_cpu_run",   32'(cpu_run),       32'd1);
    chk("mid_run_busy",      32'(busy),          32'd1);
    chk("mid_run_cmd_ready", 32'(cif.cmd_ready), 32'd0);
    chk("mid_run_cycles",    cycles_run,         32'd3);
    rstn = 1'b0;
    #1;
    chk("rst_run_cpu_run",    32'(cpu_run),       32'd0);
    chk("rst_run_busy",       32'(busy),          32'd0);
    chk("rst_run_cycles_run", cycles_run,         32'd0);
    chk("rst_run_cmd_ready",  32'(cif.cmd_ready), 32'd1);
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;

    // Randomized commands.
    for (int n = 0; n < 60; n++) begin
      op  = 2'($urandom);
      cnt = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 40));
      be  = 1'($urandom);
      ba  = (($urandom % 2) == 0) ? 32'h40 : PC_W'($urandom);
      rand_arrays(ba);
      issue(op, cnt, be, ba);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
